// File: rtl/turbo_node_sram_ctrl.sv
// rtl/turbo_node_sram_ctrl.sv - node memory responder for SRAM-backed Turbo PIFO levels
module turbo_node_sram_ctrl #(
    parameter int PTW   = 16,
    parameter int MTW   = 32,
    parameter int CTW   = 10,
    parameter int ADW   = 16,
    parameter int DEPTH = 256
) (
    input  logic                          i_clk,
    input  logic                          i_arst_n,
    input  logic                          i_rd,
    input  logic [ADW-1:0]                i_rd_addr,
    output logic                          o_rd_valid,
    output logic [4*(CTW+MTW+PTW)-1:0]    o_rd_data,
    input  logic                          i_wr,
    input  logic [ADW-1:0]                i_wr_addr,
    input  logic [4*(CTW+MTW+PTW)-1:0]    i_wr_data,
    input  logic [3:0]                    i_wr_mask,
    output logic                          o_ready,
    output logic                          o_init_done,
    output logic [1:0]                    o_err
);
    localparam int NW     = CTW + MTW + PTW;
    localparam int NODE_W = 4 * NW;
    localparam int AIW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [NW-1:0]     EMPTY_SLOT = {{(CTW + MTW){1'b0}}, {PTW{1'b1}}};
    localparam logic [NODE_W-1:0] EMPTY_NODE = {4{EMPTY_SLOT}};

    logic [0:0]        r_state;
    logic [ADW-1:0]    r_init_cnt;
    logic [NODE_W-1:0] r_mem [DEPTH];
    logic              r_s1_valid;
    logic [NODE_W-1:0] r_s1_data;
    logic [1:0]        r_err;

    logic              w_run;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_rd_inr;
    logic              w_wr_inr;
    logic              w_wr_commit;
    logic [AIW-1:0]    w_rd_idx;
    logic [AIW-1:0]    w_wr_idx;
    logic [NODE_W-1:0] w_wr_node;
    logic [NODE_W-1:0] w_rd_node;

    function automatic logic [NODE_W-1:0] f_merge(input logic [NODE_W-1:0] old_node,
                                                  input logic [NODE_W-1:0] new_node,
                                                  input logic [3:0]        mask);
        logic [NODE_W-1:0] res;
        res = old_node;
        for (int g = 0; g < 4; g++) begin
            if (mask[g]) res[g*NW +: NW] = new_node[g*NW +: NW];
        end
        return res;
    endfunction

    assign w_run       = (r_state == ST_RUN);
    assign w_rd_ok     = i_rd & w_run;
    assign w_wr_ok     = i_wr & w_run;
    assign w_rd_inr    = ({1'b0, i_rd_addr} < (ADW + 1)'(DEPTH));
    assign w_wr_inr    = ({1'b0, i_wr_addr} < (ADW + 1)'(DEPTH));
    assign w_wr_commit = w_wr_ok & w_wr_inr;
    assign w_rd_idx    = i_rd_addr[AIW-1:0];
    assign w_wr_idx    = i_wr_addr[AIW-1:0];
    assign w_wr_node   = f_merge(r_mem[w_wr_idx], i_wr_data, i_wr_mask);

    // Write-first bypass: a same-cycle write to the read address overrides only its masked slots.
    always_comb begin
        w_rd_node = w_rd_inr ? r_mem[w_rd_idx] : EMPTY_NODE;
        if (w_wr_commit && (i_wr_addr == i_rd_addr)) begin
            w_rd_node = f_merge(w_rd_node, i_wr_data, i_wr_mask);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!w_run) begin
            r_mem[r_init_cnt[AIW-1:0]] <= EMPTY_NODE;
        end else if (w_wr_commit) begin
            r_mem[w_wr_idx] <= w_wr_node;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else if (!w_run) begin
            if (r_init_cnt == ADW'(DEPTH - 1)) begin
                r_state <= ST_RUN;
            end else begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_ok;
            if (w_rd_ok) r_s1_data <= w_rd_node;
            o_rd_valid <= r_s1_valid;
            if (r_s1_valid) o_rd_data <= r_s1_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_err <= 2'b00;
        end else begin
            if ((w_rd_ok && !w_rd_inr) || (w_wr_ok && !w_wr_inr)) r_err[0] <= 1'b1;
            if (!w_run && (i_rd || i_wr)) r_err[1] <= 1'b1;
        end
    end

    assign o_ready     = w_run;
    assign o_init_done = w_run;
    assign o_err       = r_err;
endmodule

// File: tb/tb_turbo_node_sram_ctrl.sv
// tb/tb_turbo_node_sram_ctrl.sv - randomized self-checking bench for turbo_node_sram_ctrl
module tb_turbo_node_sram_ctrl;
    localparam int PTW    = 16;
    localparam int MTW    = 32;
    localparam int CTW    = 10;
    localparam int ADW    = 16;
    localparam int DEPTH  = 8;
    localparam int NW     = CTW + MTW + PTW;
    localparam int NODE_W = 4 * NW;

    localparam logic [NW-1:0]     E_SLOT = {{(CTW + MTW){1'b0}}, {PTW{1'b1}}};
    localparam logic [NODE_W-1:0] E_NODE = {4{E_SLOT}};

    logic              i_clk;
    logic              i_arst_n;
    logic              i_rd;
    logic [ADW-1:0]    i_rd_addr;
    logic              o_rd_valid;
    logic [NODE_W-1:0] o_rd_data;
    logic              i_wr;
    logic [ADW-1:0]    i_wr_addr;
    logic [NODE_W-1:0] i_wr_data;
    logic [3:0]        i_wr_mask;
    logic              o_ready;
    logic              o_init_done;
    logic [1:0]        o_err;

    turbo_node_sram_ctrl #(
        .PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW), .DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n),
        .i_rd(i_rd), .i_rd_addr(i_rd_addr),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .i_wr(i_wr), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_mask(i_wr_mask),
        .o_ready(o_ready), .o_init_done(o_init_done), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int                n_vec = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                m_edges = 0;
    logic [1:0]        m_err;
    logic [NODE_W-1:0] m_last;
    logic [NODE_W-1:0] m_mem [DEPTH];
    logic [NODE_W-1:0] q_d [$];
    int                q_due [$];

    function automatic logic [NW-1:0] mk_slot(input logic [CTW-1:0] cnt,
                                              input logic [MTW-1:0] meta,
                                              input logic [PTW-1:0] pri);
        return {cnt, meta, pri};
    endfunction

    function automatic logic [NODE_W-1:0] rnd_node();
        logic [255:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[NODE_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [NODE_W-1:0] obs, input logic [NODE_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model applies the spec rules at the sampling edge, then outputs are checked.
    task automatic step(input logic rd, input logic [ADW-1:0] ra, input logic wr,
                        input logic [ADW-1:0] wa, input logic [NODE_W-1:0] wd, input logic [3:0] wm);
        i_rd = rd; i_rd_addr = ra; i_wr = wr; i_wr_addr = wa; i_wr_data = wd; i_wr_mask = wm;
        if (m_edges >= DEPTH) begin
            if (wr && wa < DEPTH) begin
                for (int g = 0; g < 4; g++)
                    if (wm[g]) m_mem[wa][g*NW +: NW] = wd[g*NW +: NW];
            end
            if ((rd && ra >= DEPTH) || (wr && wa >= DEPTH)) m_err[0] = 1'b1;
            if (rd) begin
                q_d.push_back((ra < DEPTH) ? m_mem[ra] : E_NODE);
                q_due.push_back(cyc + 2);
            end
        end else if (rd || wr) begin
            m_err[1] = 1'b1;
        end
        @(posedge i_clk);
        cyc++;
        m_edges++;
        @(negedge i_clk);
        i_rd = 1'b0;
        i_wr = 1'b0;
        check("ready", NODE_W'(o_ready), NODE_W'(m_edges >= DEPTH));
        check("init_done", NODE_W'(o_init_done), NODE_W'(m_edges >= DEPTH));
        check("err", NODE_W'(o_err), NODE_W'(m_err));
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            m_last = q_d.pop_front();
            void'(q_due.pop_front());
            check("rd_valid", NODE_W'(o_rd_valid), NODE_W'(1'b1));
        end else begin
            check("rd_valid_idle", NODE_W'(o_rd_valid), NODE_W'(1'b0));
        end
        check("rd_data", o_rd_data, m_last);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic do_reset();
        i_rd = 1'b0; i_wr = 1'b0; i_rd_addr = '0; i_wr_addr = '0; i_wr_data = '0; i_wr_mask = '0;
        i_arst_n = 1'b0;
        #1;
        check("rst_valid", NODE_W'(o_rd_valid), NODE_W'(1'b0));
        check("rst_data", o_rd_data, '0);
        check("rst_ready", NODE_W'(o_ready), NODE_W'(1'b0));
        check("rst_init_done", NODE_W'(o_init_done), NODE_W'(1'b0));
        check("rst_err", NODE_W'(o_err), NODE_W'(2'b00));
        q_d.delete();
        q_due.delete();
        m_err = 2'b00;
        m_last = '0;
        m_edges = 0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = E_NODE;
        @(negedge i_clk);
        @(negedge i_clk);
        i_arst_n = 1'b1;
    endtask

    initial begin
        logic [NODE_W-1:0] wd;
        i_arst_n = 1'b1;
        i_rd = 1'b0; i_wr = 1'b0; i_rd_addr = '0; i_wr_addr = '0; i_wr_data = '0; i_wr_mask = '0;
        #2;
        do_reset();
        idle(DEPTH);

        step(1'b1, ADW'(3), 1'b0, '0, '0, 4'h0);
        idle(2);
        check("empty_slot3_pri", NODE_W'(o_rd_data[3*NW +: PTW]), NODE_W'(16'hFFFF));

        wd = {mk_slot(10'd4, $urandom, 16'd40), mk_slot(10'd3, $urandom, 16'd30),
              mk_slot(10'd2, $urandom, 16'd20), mk_slot(10'd1, $urandom, 16'd10)};
        step(1'b0, '0, 1'b1, ADW'(5), wd, 4'hF);
        step(1'b1, ADW'(5), 1'b0, '0, '0, 4'h0);
        idle(2);

        wd = rnd_node();
        wd[2*NW +: NW] = mk_slot(10'd9, 32'h1234, 16'd7);
        step(1'b0, '0, 1'b1, ADW'(5), wd, 4'b0100);
        step(1'b1, ADW'(5), 1'b0, '0, '0, 4'h0);
        idle(2);
        check("mask_slot2_pri", NODE_W'(o_rd_data[2*NW +: PTW]), NODE_W'(16'd7));
        check("mask_slot0_pri", NODE_W'(o_rd_data[0 +: PTW]), NODE_W'(16'd10));
        check("mask_slot3_pri", NODE_W'(o_rd_data[3*NW +: PTW]), NODE_W'(16'd40));

        step(1'b1, ADW'(2), 1'b1, ADW'(2), rnd_node(), 4'b1011);
        step(1'b1, ADW'(2), 1'b0, '0, '0, 4'h0);
        step(1'b0, '0, 1'b1, ADW'(2), rnd_node(), 4'hF);
        idle(2);

        step(1'b1, ADW'(1), 1'b0, '0, '0, 4'h0);
        step(1'b1, ADW'(2), 1'b0, '0, '0, 4'h0);
        step(1'b1, ADW'(3), 1'b0, '0, '0, 4'h0);
        idle(2);

        step(1'b1, ADW'(9), 1'b0, '0, '0, 4'h0);
        idle(2);
        check("oor_err", NODE_W'(o_err), NODE_W'(2'b01));
        step(1'b0, '0, 1'b1, ADW'(13), rnd_node(), 4'hF);
        step(1'b1, ADW'(5), 1'b0, '0, '0, 4'h0);
        idle(2);

        for (int a = 0; a < 4; a++) step(1'b1, ADW'(a), 1'b0, '0, '0, 4'h0);
        do_reset();
        step(1'b1, ADW'(3), 1'b0, '0, '0, 4'h0);
        step(1'b0, '0, 1'b1, ADW'(4), rnd_node(), 4'hF);
        while (m_edges < DEPTH) idle(1);
        for (int a = 0; a < DEPTH; a++) step(1'b1, ADW'(a), 1'b0, '0, '0, 4'h0);
        idle(2);

        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), ADW'($urandom_range(0, DEPTH + 1)),
                 1'($urandom_range(0, 1)), ADW'($urandom_range(0, DEPTH + 1)),
                 rnd_node(), 4'($urandom_range(0, 15)));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/turbo_node_sram_ctrl.md
Name: turbo_node_sram_ctrl

Overview:
Node-memory responder for non-root Turbo PIFO engine levels. It serves the engines' node read requests with a fixed two-cycle latency and accepts per-slot masked write-backs of updated nodes. After reset it initialises every node to the empty state. One instance sits beside each SRAM-backed level of the pipeline.

Parameters:
PTW, 16, priority field width per slot
MTW, 32, metadata field width per slot
CTW, 10, subtree counter width per slot
ADW, 16, node address width
DEPTH, 256, number of nodes stored (DEPTH <= 2^ADW)

Ports:
i_clk  in  1  clock
i_arst_n  in  1  asynchronous active-low reset
i_rd  in  1  node read request (driven by engine o_sram_rd)
i_rd_addr  in  ADW  node address of read
o_rd_valid  out  1  read data valid
o_rd_data  out  4*NW  node data, NW=CTW+MTW+PTW
i_wr  in  1  node write request
i_wr_addr  in  ADW  node address of write
i_wr_data  in  4*NW  node write data
i_wr_mask  in  4  per-slot write enable; bit g covers slot g
o_ready  out  1  high when accepting accesses (state RUN)
o_init_done  out  1  high once initial sweep has completed
o_err  out  2  sticky errors: [0] address >= DEPTH, [1] access while not ready

Behaviour:
- Reset is i_arst_n, asynchronous and active-low. Clock is i_clk.
- Node layout:
  - Slot g occupies bits [g*NW +: NW].
  - Within a slot: priority [PTW-1:0], then metadata [PTW +: MTW], then count [PTW+MTW +: CTW].
- EMPTY slot value: count = 0, metadata = 0, priority = all ones. EMPTY node = 4 EMPTY slots.
- Reset values: o_rd_valid=0, o_rd_data=0, o_ready=0, o_init_done=0, o_err=0. Read pipeline is flushed. FSM enters INIT with init counter = 0.
- FSM:
  - INIT: each cycle writes an EMPTY node at the init counter address, then increments the counter. After writing address DEPTH-1, the FSM goes to RUN. o_ready=0 throughout INIT.
  - RUN: o_ready=1 and o_init_done=1, both from the first RUN cycle. RUN is left only on reset.
  - The first RUN cycle is exactly DEPTH cycles after the first clock edge with reset deasserted.
- Reads:
  - A read accepted in cycle N (i_rd=1 in RUN) produces o_rd_valid=1 with o_rd_data in cycle N+2.
  - Fully pipelined: one read accepted per cycle, responses returned in request order.
  - o_rd_valid is high for exactly one cycle per accepted read.
  - o_rd_data holds its last value when o_rd_valid=0.
- Writes:
  - A write accepted in cycle N (i_wr=1 in RUN) updates only the slots whose i_wr_mask bit is 1, at the end of cycle N.
  - i_wr_mask=0 is a legal no-op.
- Ordering:
  - Read data reflects every write accepted in cycles <= N, where N is the read's request cycle.
  - A read and a write to the same address in the same cycle is write-first: the masked slots return the new data, the others return the stored data.
  - Writes accepted in cycle N+1 or later are not visible to the read from cycle N.
- Out-of-range address (>= DEPTH):
  - Read: returns an EMPTY node with normal latency and valid, and sets o_err[0].
  - Write: ignored, and sets o_err[0].
- Access while not ready: i_rd or i_wr asserted in INIT is dropped (no o_rd_valid, no write) and sets o_err[1].
- o_err bits are sticky and clear only on reset.
- Reset mid-operation: outputs return immediately to their reset values. In-flight reads are discarded and produce no response. INIT reruns and overwrites the entire array.
- Storage array needs no reset; INIT provides its defined contents.

Test Plan:
- DEPTH=8: release reset -> o_ready and o_init_done rise on cycle 8. Read addr 3 -> two cycles later o_rd_valid=1 and all 4 slots read pri=0xFFFF, meta=0, cnt=0.
- Write addr 5, mask 4'b1111, slot pris 10/20/30/40 with cnt 1/2/3/4; read addr 5 next cycle -> data matches exactly with latency 2.
- Masked write addr 5, mask 4'b0100, slot2 pri=7 -> readback shows slot2 pri=7 and slots 0/1/3 unchanged (10/20/40).
- Same-cycle write and read of addr 2 -> returned data is the new data. Write addr 2 one cycle after a read of addr 2 -> that read returns the old data.
- Reads of addrs 1, 2, 3 in consecutive cycles N..N+2 -> o_rd_valid high in N+2..N+4 with data in order and no gaps.
- Read addr 9 (DEPTH=8) -> EMPTY node returned and o_err=2'b01. i_rd during INIT -> no response and o_err[1]=1. Assert reset mid-burst -> o_rd_valid drops at once, o_ready=0, INIT reruns for 8 cycles, and all nodes read EMPTY afterwards.
